// File: rtl/fp16_pkg.sv
// Shared types and constants for the fp16 multiplier normalize/round slice.
//   BIAS_DEF : default exponent bias
//   EXP_INF  : all-ones exponent field used for infinity
//   MANT_W   : stored mantissa width
//   PROD_W   : width of the hidden-one mantissa product
//   norm_t   : stage-1 register contents (normalized, not yet rounded)
//   res_t    : packed binary16 result plus status flags
package fp16_pkg;

   localparam int unsigned BIAS_DEF = 15;
   localparam logic [4:0]  EXP_INF  = 5'h1F;
   localparam int unsigned MANT_W   = 10;
   localparam int unsigned PROD_W   = 22;

   typedef struct packed {
      logic              sign;
      logic [8:0]        exp;     // two's complement, unbiased-then-rebiased
      logic [MANT_W-1:0] mant;
      logic              guard;
      logic              sticky;
      logic              zero;
   } norm_t;

   typedef struct packed {
      logic [15:0] result;
      logic        ovf;
      logic        unf;
      logic        inexact;
   } res_t;

endpackage

// File: rtl/fp16_norm_round_if.sv
// Handshake bundle between the fp16 multiplier core, the normalize/round
// stage and its consumer.
//   in_*  : product terms from the multiplier core with valid/ready
//   out_* : packed binary16 result and flags with valid/ready
// Modports: master = product source / result sink, slave = the stage.
interface fp16_norm_round_if #(
   parameter int unsigned EXP_W = 7
);
   import fp16_pkg::*;

   logic              in_valid;
   logic              in_ready;
   logic              in_sign;
   logic [EXP_W-1:0]  in_exp_sum;
   logic [PROD_W-1:0] in_mant_prod;
   logic              in_zero;
   logic              out_valid;
   logic              out_ready;
   logic [15:0]       out_result;
   logic              out_ovf;
   logic              out_unf;
   logic              out_inexact;

   modport master (
      output in_valid, in_sign, in_exp_sum, in_mant_prod, in_zero, out_ready,
      input  in_ready, out_valid, out_result, out_ovf, out_unf, out_inexact
   );

   modport slave (
      input  in_valid, in_sign, in_exp_sum, in_mant_prod, in_zero, out_ready,
      output in_ready, out_valid, out_result, out_ovf, out_unf, out_inexact
   );

endinterface

// File: rtl/fp16_round.sv
// Combinational round-and-pack for a normalized fp16 product.
//   norm_i : normalized sign/exponent/mantissa with guard and sticky bits
//   res_o  : packed binary16 result plus ovf/unf/inexact
// Build macro FP16_RNE_EN: defined selects round-to-nearest-even, undefined
// selects truncation (inexact is still reported).
module fp16_round
   import fp16_pkg::*;
(
   input  norm_t norm_i,
   output res_t  res_o
);

   logic              round_up;
   logic [MANT_W:0]   mant_sum;
   logic signed [9:0] exp_s;

   always_comb begin
`ifdef FP16_RNE_EN
      round_up = norm_i.guard & (norm_i.sticky | norm_i.mant[0]);
`else
      round_up = 1'b0;
`endif
      mant_sum = {1'b0, norm_i.mant} + {{MANT_W{1'b0}}, round_up};
      // Mantissa carry-out bumps the exponent; the wrapped mantissa is already 0.
      exp_s    = 10'(signed'(norm_i.exp)) + 10'(mant_sum[MANT_W]);

      res_o = '0;
      if (norm_i.zero) begin
         res_o.result = {norm_i.sign, 15'h0};
      end else if (exp_s >= 10'sd31) begin
         res_o.result  = {norm_i.sign, EXP_INF, 10'h0};
         res_o.ovf     = 1'b1;
         res_o.inexact = 1'b1;
      end else if (exp_s <= 10'sd0) begin
         // No subnormals: anything below the normal range flushes to zero.
         res_o.result  = {norm_i.sign, 15'h0};
         res_o.unf     = 1'b1;
         res_o.inexact = 1'b1;
      end else begin
         res_o.result  = {norm_i.sign, exp_s[4:0], mant_sum[MANT_W-1:0]};
         res_o.inexact = norm_i.guard | norm_i.sticky;
      end
   end

endmodule

// File: rtl/fp16_norm_round.sv
// Two-stage normalize-and-round pipeline for the fp16 multiplier.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset, discards all in-flight products
//   bus   : slave side of fp16_norm_round_if (product in, result out)
// Stage 1 normalizes the 22-bit product, stage 2 holds the rounded result.
// Build macro FP16_RNE_EN selects rounding mode inside fp16_round.
module fp16_norm_round
   import fp16_pkg::*;
#(
   parameter int unsigned BIAS  = BIAS_DEF,
   parameter int unsigned EXP_W = 7
) (
   input logic              clk,
   input logic              rst_n,
   fp16_norm_round_if.slave bus
);

   logic             s1_valid_q, s1_valid_d;
   logic             s2_valid_q, s2_valid_d;
   logic             s1_load, s2_load, s2_adv;
   norm_t            s1_q, s1_d;
   res_t             s2_q, rnd;
   logic [EXP_W-1:0] exp_sum;
   logic [8:0]       exp_unb;

   assign exp_sum = bus.in_exp_sum;

   // Handshake: a stage loads when empty or when its successor advances.
   always_comb begin
      s2_adv       = !s2_valid_q | bus.out_ready;
      bus.in_ready = !s1_valid_q | s2_adv;
      s1_load      = bus.in_valid & bus.in_ready;
      s2_load      = s1_valid_q & s2_adv;
      s1_valid_d   = s1_load | (s1_valid_q & !s2_adv);
      s2_valid_d   = s2_load | (s2_valid_q & !bus.out_ready);
   end

   // Stage 1: normalize so the hidden one sits just above mant.
   always_comb begin
      s1_d      = '0;
      s1_d.sign = bus.in_sign;
      s1_d.zero = bus.in_zero;
      exp_unb   = 9'(exp_sum) - 9'(BIAS);
      if (bus.in_mant_prod[PROD_W-1]) begin
         s1_d.mant   = bus.in_mant_prod[20:11];
         s1_d.guard  = bus.in_mant_prod[10];
         s1_d.sticky = |bus.in_mant_prod[9:0];
         s1_d.exp    = exp_unb + 9'd1;
      end else begin
         s1_d.mant   = bus.in_mant_prod[19:10];
         s1_d.guard  = bus.in_mant_prod[9];
         s1_d.sticky = |bus.in_mant_prod[8:0];
         s1_d.exp    = exp_unb;
      end
   end

   fp16_round u_round (
      .norm_i (s1_q),
      .res_o  (rnd)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_valid_q <= 1'b0;
         s2_valid_q <= 1'b0;
         s2_q       <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s2_valid_q <= s2_valid_d;
         if (s2_load) begin
            s2_q <= rnd;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (s1_load) begin
         s1_q <= s1_d;
      end
   end

   // Outputs read zero whenever no result is being presented.
   always_comb begin
      bus.out_valid   = s2_valid_q;
      bus.out_result  = s2_valid_q ? s2_q.result : 16'h0;
      bus.out_ovf     = s2_valid_q & s2_q.ovf;
      bus.out_unf     = s2_valid_q & s2_q.unf;
      bus.out_inexact = s2_valid_q & s2_q.inexact;
   end

endmodule

// File: tb/tb_fp16_norm_round.sv
// Self-checking bench for fp16_norm_round: directed cases with literal
// expectations, backpressure and reset scenarios, then randomized traffic
// scored against an arithmetic reference model.
`timescale 1ns/1ps
module tb_fp16_norm_round;
   import fp16_pkg::*;

   localparam int unsigned EXP_W = 7;
   localparam int          BIAS  = 15;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   fp16_norm_round_if #(.EXP_W(EXP_W)) bus ();

   fp16_norm_round #(
      .BIAS  (BIAS),
      .EXP_W (EXP_W)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int          n_tests = 0;
   int          n_fail  = 0;
   int          n_emit  = 0;
   logic [18:0] exp_q[$];
   logic        hold_v  = 1'b0;
   logic [18:0] hold_val;
   logic [18:0] dut_out;

   assign dut_out = {bus.out_result, bus.out_ovf, bus.out_unf, bus.out_inexact};

   // Reference: value = prod * 2^(exp_sum - BIAS - 20); keep 11 significant bits.
   function automatic logic [18:0] model(input logic s, input int es, input int p,
                                         input logic z);
      int   e, msb, sh, kept, rem;
      logic inx;
      if (z) return {s, 15'h0, 3'b000};
      msb = 21;
      while (msb > 0 && ((p >> msb) & 1) == 0) msb--;
      sh   = msb - 10;
      kept = p >> sh;
      rem  = p - (kept << sh);
      e    = es - BIAS + (msb - 20);
      inx  = (rem != 0);
`ifdef FP16_RNE_EN
      begin
         int half;
         half = 1 << (sh - 1);
         if (rem > half || (rem == half && (kept % 2) == 1)) kept++;
         if (kept == 2048) begin
            kept = 1024;
            e++;
         end
      end
`endif
      if (e >= 31) return {s, 5'h1F, 10'h0, 3'b101};
      if (e <= 0) return {s, 15'h0, 3'b011};
      return {s, 5'(e), 10'(kept), 2'b00, inx};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, req);
      end
   endtask

   // Single compare process: scoreboard, idle-zero and stall-stability checks.
   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
         hold_v = 1'b0;
      end else begin
         if (hold_v) check("hold_stable", {bus.out_valid, dut_out}, {1'b1, hold_val});
         if (!bus.out_valid) check("idle_zero", dut_out, 0);
         if (bus.in_valid && bus.in_ready)
            exp_q.push_back(model(bus.in_sign, bus.in_exp_sum, bus.in_mant_prod, bus.in_zero));
         if (bus.out_valid && bus.out_ready) begin
            n_emit++;
            if (exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_result: got %h, expected nothing", dut_out);
            end else begin
               check("stream", dut_out, exp_q.pop_front());
            end
         end
         hold_v   = bus.out_valid && !bus.out_ready;
         hold_val = dut_out;
      end
   end

   task automatic set_in(input logic s, input logic [6:0] es, input logic [21:0] p,
                         input logic z);
      bus.in_sign      = s;
      bus.in_exp_sum   = es;
      bus.in_mant_prod = p;
      bus.in_zero      = z;
      bus.in_valid     = 1'b1;
   endtask

   // Offer one product and hold it until accepted; returns at posedge+1.
   task automatic push(input logic s, input logic [6:0] es, input logic [21:0] p,
                       input logic z);
      int waited = 0;
      set_in(s, es, p, z);
      @(negedge clk);
      while (!bus.in_ready && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      if (!bus.in_ready) begin
         n_tests++;
         n_fail++;
         $display("FAIL push_timeout: in_ready got 0, expected 1 within 50 cycles");
      end
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
   endtask

   // Isolated transaction on an empty pipe with out_ready high.
   task automatic one_shot(input string name, input logic s, input logic [6:0] es,
                           input logic [21:0] p, input logic z, input logic [18:0] lit);
      check({name, "_model"}, model(s, es, p, z), lit);
      @(posedge clk);
      #1;
      set_in(s, es, p, z);
      @(negedge clk);
      check({name, "_ready"}, bus.in_ready, 1);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      @(negedge clk);
      check({name, "_lat1"}, bus.out_valid, 0);
      @(negedge clk);
      check({name, "_lat2"}, bus.out_valid, 1);
      check({name, "_result"}, dut_out, lit);
   endtask

   task automatic drain();
      int waited = 0;
      bus.out_ready = 1'b1;
      while (exp_q.size() != 0 && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      check("drain_empty", exp_q.size(), 0);
      @(posedge clk);
      #1;
   endtask

   logic done;

   initial begin
      int e0, seen;
      rst_n = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_sign = 1'b0;
      bus.in_exp_sum = '0;
      bus.in_mant_prod = '0;
      bus.in_zero = 1'b0;
      bus.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_valid", bus.out_valid, 0);
      check("reset_result", dut_out, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("reset_ready", bus.in_ready, 1);

      one_shot("one", 1'b0, 7'd30, 22'h100000, 1'b0, {16'h3C00, 3'b000});
      one_shot("sq15", 1'b0, 7'd30, 22'h240000, 1'b0, {16'h4080, 3'b000});
`ifdef FP16_RNE_EN
      one_shot("rcarry", 1'b0, 7'd30, 22'h1FFE00, 1'b0, {16'h4000, 3'b001});
      one_shot("tie_odd", 1'b0, 7'd30, 22'h200C00, 1'b0, {16'h4002, 3'b001});
      one_shot("above", 1'b0, 7'd30, 22'h100201, 1'b0, {16'h3C01, 3'b001});
      one_shot("emax_c", 1'b0, 7'd45, 22'h1FFE00, 1'b0, {16'h7C00, 3'b101});
`else
      one_shot("rcarry", 1'b0, 7'd30, 22'h1FFE00, 1'b0, {16'h3FFF, 3'b001});
      one_shot("tie_odd", 1'b0, 7'd30, 22'h200C00, 1'b0, {16'h4001, 3'b001});
      one_shot("above", 1'b0, 7'd30, 22'h100201, 1'b0, {16'h3C00, 3'b001});
      one_shot("emax_c", 1'b0, 7'd45, 22'h1FFE00, 1'b0, {16'h7BFF, 3'b001});
`endif
      one_shot("tie_even", 1'b0, 7'd30, 22'h100200, 1'b0, {16'h3C00, 3'b001});
      one_shot("ovf", 1'b0, 7'd60, 22'h100000, 1'b0, {16'h7C00, 3'b101});
      one_shot("unf", 1'b1, 7'd10, 22'h100000, 1'b0, {16'h8000, 3'b011});
      one_shot("zero", 1'b1, 7'd30, 22'h240000, 1'b1, {16'h8000, 3'b000});
      one_shot("emin", 1'b0, 7'd16, 22'h100000, 1'b0, {16'h0400, 3'b000});
      one_shot("ezero", 1'b0, 7'd15, 22'h100000, 1'b0, {16'h0000, 3'b011});
      one_shot("emax", 1'b0, 7'd45, 22'h100000, 1'b0, {16'h7800, 3'b000});
      @(posedge clk);
      #1;

      // Backpressure: out_ready low for three offer cycles.
      e0 = n_emit;
      bus.out_ready = 1'b0;
      set_in(1'b0, 7'd30, 22'h100000, 1'b0);
      @(negedge clk);
      check("bp_acc0", bus.in_ready, 1);
      @(posedge clk);
      #1;
      set_in(1'b0, 7'd31, 22'h240000, 1'b0);
      @(negedge clk);
      check("bp_acc1", bus.in_ready, 1);
      @(posedge clk);
      #1;
      set_in(1'b1, 7'd29, 22'h1FFE00, 1'b0);
      @(negedge clk);
      check("bp_full", bus.in_ready, 0);
      check("bp_outv", bus.out_valid, 1);
      @(posedge clk);
      #1;
      bus.out_ready = 1'b1;
      push(1'b1, 7'd29, 22'h1FFE00, 1'b0);
      push(1'b0, 7'd20, 22'h3FFFFF, 1'b0);
      drain();
      check("bp_count", n_emit - e0, 4);

      // Reset with both stages full.
      bus.out_ready = 1'b0;
      push(1'b0, 7'd30, 22'h100000, 1'b0);
      push(1'b1, 7'd33, 22'h240000, 1'b0);
      @(negedge clk);
      check("rst_full", bus.in_ready, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      check("rst_mid_valid", bus.out_valid, 0);
      check("rst_mid_result", dut_out, 0);
      rst_n = 1'b1;
      bus.out_ready = 1'b1;
      @(negedge clk);
      check("rst_rel_ready", bus.in_ready, 1);
      seen = 0;
      repeat (5) begin
         @(negedge clk);
         if (bus.out_valid) seen++;
      end
      check("rst_no_stale", seen, 0);
      @(posedge clk);
      #1;

      // Randomized traffic with random backpressure.
      done = 1'b0;
      fork
         begin
            for (int k = 0; k < 300; k++) begin
               int          a, b, sel;
               logic [6:0]  es;
               logic [21:0] p;
               a   = 1024 + $urandom_range(0, 1023);
               b   = 1024 + $urandom_range(0, 1023);
               p   = 22'(a * b);
               sel = $urandom_range(0, 3);
               if (sel == 0) es = 7'($urandom_range(13, 17));
               else if (sel == 1) es = 7'($urandom_range(43, 47));
               else es = 7'($urandom_range(0, 62));
               push(1'($urandom_range(0, 1)), es, p, ($urandom_range(0, 15) == 0));
               if ($urandom_range(0, 3) == 0) begin
                  repeat ($urandom_range(1, 3)) begin
                     @(posedge clk);
                     #1;
                  end
               end
            end
            done = 1'b1;
         end
         begin
            while (!done) begin
               @(posedge clk);
               #1;
               bus.out_ready = ($urandom_range(0, 2) != 0);
            end
         end
      join
      drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation got no finish, expected one before 400us");
      $fatal(1, "watchdog expired");
   end

endmodule
